// File: rtl/mandel_julia.sv
// mandel_julia: iterative Mandelbrot/Julia escape-time engine sharing one signed multiplier.
// Each iteration takes four cycles: x*x, y*y, x*y, then the escape/limit check.
module mandel_julia #(
    parameter int FP_WIDTH = 25,
    parameter int FP_INT   = 4,
    parameter int ITERW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [FP_WIDTH-1:0] re,
    input  logic signed [FP_WIDTH-1:0] im,
    input  logic signed [FP_WIDTH-1:0] c_re,
    input  logic signed [FP_WIDTH-1:0] c_im,
    input  logic [ITERW-1:0]           iter_limit,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ITERW-1:0]           iter,
    output logic                       escaped
);
    localparam int W    = FP_WIDTH;
    localparam int FRAC = W - FP_INT;
    localparam logic [W+4:0] FOUR = (W+5)'(4) << FRAC;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MUL_XX = 3'd1;
    localparam logic [2:0] MUL_YY = 3'd2;
    localparam logic [2:0] MUL_XY = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d, cr_q, cr_d, ci_q, ci_d, xy_q, xy_d;
    logic signed [W+3:0] x2_q, x2_d, y2_q, y2_d;
    logic [ITERW-1:0]    cnt_q, cnt_d, lim_q, lim_d;
    logic                esc_q, esc_d;

    logic signed [W-1:0]   mul_a, mul_b, nx, ny;
    logic signed [2*W-1:0] prod;
    logic signed [W+3:0]   prod_sh;
    logic [W+4:0]          mag;
    logic                  esc, busy;

    // Operand steering lets a single multiplier serve all three products.
    assign mul_a   = (state_q == MUL_YY) ? y_q : x_q;
    assign mul_b   = (state_q == MUL_XX) ? x_q : y_q;
    assign prod    = (2*W)'(mul_a) * (2*W)'(mul_b);
    assign prod_sh = (W+4)'(prod >>> FRAC);
    assign mag     = {1'b0, x2_q} + {1'b0, y2_q};
    assign esc     = mag > FOUR;
    assign nx      = W'((W+5)'(x2_q) - (W+5)'(y2_q) + (W+5)'(cr_q));
    assign ny      = W'(((W+5)'(xy_q) <<< 1) + (W+5)'(ci_q));
    assign busy    = (state_q == MUL_XX) || (state_q == MUL_YY) || (state_q == MUL_XY) || (state_q == CHECK);

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign iter      = cnt_q;
    assign escaped   = esc_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        xy_d    = xy_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        esc_d   = esc_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = MUL_XX;
                x_d     = mode ? re : '0;
                y_d     = mode ? im : '0;
                cr_d    = mode ? c_re : re;
                ci_d    = mode ? c_im : im;
                lim_d   = iter_limit;
                cnt_d   = '0;
                esc_d   = 1'b0;
            end
            MUL_XX: begin
                x2_d    = prod_sh;
                state_d = MUL_YY;
            end
            MUL_YY: begin
                y2_d    = prod_sh;
                state_d = MUL_XY;
            end
            MUL_XY: begin
                xy_d    = prod_sh[W-1:0];
                state_d = CHECK;
            end
            CHECK: if (esc || cnt_q == lim_q) begin
                state_d = DONE;
                esc_d   = esc;
            end else begin
                x_d     = nx;
                y_d     = ny;
                cnt_d   = cnt_q + ITERW'(1);
                state_d = MUL_XX;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (abort && busy) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            xy_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            xy_q    <= xy_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            esc_q   <= esc_d;
        end
    end
endmodule

// File: tb/tb_mandel_julia.sv
// tb_mandel_julia: table-driven and randomized checks of mandel_julia against an escape-time model.
module tb_mandel_julia;
    localparam int W = 25;
    localparam int FRAC = 21;
    localparam int IW = 8;
    localparam longint ONE = 64'sd1 <<< FRAC;

    logic clk = 1'b0, rst_n = 1'b1, mode = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic signed [W-1:0] re = '0, im = '0, c_re = '0, c_im = '0;
    logic [IW-1:0] iter_limit = '0;
    logic in_ready, out_valid, escaped;
    logic [IW-1:0] iter;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    mandel_julia #(.FP_WIDTH(W), .FP_INT(4), .ITERW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .re(re), .im(im), .c_re(c_re), .c_im(c_im), .iter_limit(iter_limit), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .iter(iter), .escaped(escaped)
    );

    typedef struct {
        bit md;
        longint re, im, cre, cim;
        int lim;
        int it;
        bit es;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint wrapw(input longint v);
        return (v <<< (64 - W)) >>> (64 - W);
    endfunction

    // Escape-time iteration in plain integer fixed-point arithmetic.
    function automatic void model(input bit md, input longint r, input longint i, input longint cr,
                                  input longint ci, input int lim, output int it, output bit es);
        longint x, y, a, b, x2, y2, xy;
        x = md ? r : 0;
        y = md ? i : 0;
        a = md ? cr : r;
        b = md ? ci : i;
        it = lim;
        es = 0;
        for (int n = 0; n <= lim; n++) begin
            x2 = (x * x) >>> FRAC;
            y2 = (y * y) >>> FRAC;
            xy = wrapw((x * y) >>> FRAC);
            if (x2 + y2 > 4 * ONE) begin
                it = n;
                es = 1;
                return;
            end
            if (n == lim) return;
            x = wrapw(x2 - y2 + a);
            y = wrapw(2 * xy + b);
        end
    endfunction

    function automatic longint rnd(input longint m);
        return longint'($urandom_range(0, 32'(2 * m))) - m;
    endfunction

    task automatic accept(input bit md, input longint r, input longint i, input longint cr,
                          input longint ci, input int lim);
        @(negedge clk);
        mode = md; re = W'(r); im = W'(i); c_re = W'(cr); c_im = W'(ci);
        iter_limit = IW'(lim); in_valid = 1'b1;
        chk("in_ready_before_accept", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode = 1'($urandom); re = W'($urandom); im = W'($urandom);
        c_re = W'($urandom); c_im = W'($urandom); iter_limit = IW'($urandom);
    endtask

    task automatic run_job(input string nm, input bit md, input longint r, input longint i,
                           input longint cr, input longint ci, input int lim,
                           input int eit, input bit ees, input int hold);
        int lat;
        accept(md, r, i, cr, ci, lim);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 2000);
        chk({nm, "_latency"}, lat, 4 * (eit + 1));
        chk({nm, "_iter"}, longint'(iter), eit);
        chk({nm, "_escaped"}, longint'(escaped), ees);
        if (out_valid) begin
            repeat (hold) begin
                @(negedge clk);
                abort = 1'b1;
                @(posedge clk);
                #1;
                chk({nm, "_hold_valid"}, longint'(out_valid), 1);
                chk({nm, "_hold_iter"}, longint'(iter), eit);
                chk({nm, "_hold_escaped"}, longint'(escaped), ees);
                chk({nm, "_hold_in_ready"}, longint'(in_ready), 0);
            end
            @(negedge clk);
            abort = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({nm, "_in_ready_after"}, longint'(in_ready), 1);
            chk({nm, "_valid_after"}, longint'(out_valid), 0);
        end
    endtask

    initial begin
        int eit;
        bit ees, md, seen;
        longint r, i, cr, ci;
        int lim;
        vt[0] = '{0, 0, 0, 0, 0, 10, 10, 0};
        vt[1] = '{0, 5 * ONE / 2, 0, 0, 0, 255, 1, 1};
        vt[2] = '{1, 3 * ONE, 0, 0, 0, 255, 0, 1};
        vt[3] = '{1, ONE / 2, 0, 0, 0, 20, 20, 0};
        vt[4] = '{1, 2 * ONE, 0, 0, 0, 0, 0, 0};
        vt[5] = '{1, 2 * ONE, 0, 0, 0, 5, 1, 1};
        vt[6] = '{0, 5 * ONE / 2, 0, 0, 0, 1, 1, 1};
        vt[7] = '{0, -2 * ONE, 0, 0, 0, 50, 50, 0};
        vt[8] = '{1, 0, ONE, 0, 0, 7, 7, 0};

        #2 rst_n = 1'b0;
        #20;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_iter", longint'(iter), 0);
        chk("reset_escaped", longint'(escaped), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++)
            run_job($sformatf("vec%0d", k), vt[k].md, vt[k].re, vt[k].im, vt[k].cre, vt[k].cim,
                    vt[k].lim, vt[k].it, vt[k].es, 0);

        run_job("hold_done", 0, 0, 0, 0, 0, 3, 3, 0, 10);

        accept(0, 0, 0, 0, 0, 10);
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_out_valid", longint'(out_valid), 0);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid_later", longint'(seen), 0);
        run_job("after_abort", 0, 0, 0, 0, 0, 10, 10, 0, 0);

        accept(0, ONE / 4, 0, 0, 0, 20);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", longint'(in_ready), 1);
        chk("midreset_out_valid", longint'(out_valid), 0);
        chk("midreset_iter", longint'(iter), 0);
        chk("midreset_escaped", longint'(escaped), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("after_reset", 0, 5 * ONE / 2, 0, 0, 0, 255, 1, 1, 0);

        for (int k = 0; k < 30; k++) begin
            md = 1'($urandom_range(0, 1));
            r = md ? rnd(2 * ONE) : rnd(5 * ONE / 2);
            i = md ? rnd(2 * ONE) : rnd(5 * ONE / 2);
            cr = rnd(ONE);
            ci = rnd(ONE);
            lim = int'($urandom_range(0, 40));
            model(md, r, i, cr, ci, lim, eit, ees);
            run_job($sformatf("rand%0d", k), md, r, i, cr, ci, lim, eit, ees, (k % 5 == 0) ? 2 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
